// File: rtl/sim_host_console.sv
`timescale 1ns/1ps
// sim_host_console
// Memory-mapped host-I/O endpoint on the core 0 data bus. Stores to the upper
// half of the address space (addr_i[31]=1) are host-I/O accesses:
//   - a store of FINI_CODE ends the run,
//   - any other store queues its low byte in a character FIFO for an external drain.
// The block also keeps the run-control counters (mcycle, minstret, branch
// statistics) and forces the run to end once mcycle passes TIMEOUT_CYCLES.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   wvalid_i/addr_i/wdata_i CPU store strobe, address and data
//   retire_i               one instruction retires this cycle
//   ctrl_tsfr_i            the retiring instruction is a branch or jump
//   br_misp_i              that branch or jump was mispredicted
//   busy_o                 FIFO full, the CPU must hold its store
//   char_valid_o/char_data_o/char_ready_i  character drain handshake
//   fini_o, timeout_o, done_o, overflow_o  sticky run-status flags
//   mcycle_o, minstret_o, br_pred_o, br_misp_o  64-bit counters
//
// Drain handshake: a byte moves from the FIFO head to the drain on every
// clock edge where char_valid_o and char_ready_i are both high. char_ready_i
// with char_valid_o low is ignored. There is no handshake on the store side:
// a store that arrives while busy_o is high is dropped and flagged.
//
// Run state (signal 'state'): RUN counts and accepts stores, DRAIN waits for
// the FIFO to empty after the run ended, DONE holds until reset.
module sim_host_console #(
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter logic [31:0] FINI_CODE      = 32'h00020000,
   parameter logic [63:0] TIMEOUT_CYCLES = 64'd1000000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wvalid_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        retire_i,
   input  logic        ctrl_tsfr_i,
   input  logic        br_misp_i,
   output logic        busy_o,
   output logic        char_valid_o,
   output logic [7:0]  char_data_o,
   input  logic        char_ready_i,
   output logic        fini_o,
   output logic        timeout_o,
   output logic        done_o,
   output logic        overflow_o,
   output logic [63:0] mcycle_o,
   output logic [63:0] minstret_o,
   output logic [63:0] br_pred_o,
   output logic [63:0] br_misp_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;

   logic in_run;
   logic full;
   logic empty;
   logic hit;
   logic fini_hit;
   logic char_hit;
   logic push;
   logic pop;
   logic drop;
   logic timeout_evt;
   logic fini_evt;
   logic cnt_en;

   // Only bit 31 of the address selects this endpoint.
   logic unused_addr;
   assign unused_addr = ^addr_i[30:0];

   assign in_run   = (state == ST_RUN);
   assign full     = (count == DEPTH_C);
   assign empty    = (count == '0);

   assign hit      = wvalid_i && addr_i[31] && in_run;
   assign fini_hit = hit && (wdata_i == FINI_CODE);
   assign char_hit = hit && !fini_hit;
   // Fullness is judged on the current count only, so a pop in the same cycle
   // does not make room for a store that arrives while full.
   assign push     = char_hit && !full;
   assign drop     = char_hit && full;
   assign pop      = !empty && char_ready_i;

   assign timeout_evt = in_run && (mcycle_o > TIMEOUT_CYCLES);
   assign fini_evt    = fini_hit || timeout_evt;
   // The cycle that ends the run does not count.
   assign cnt_en      = in_run && !fini_evt;

   assign busy_o       = full;
   assign char_valid_o = !empty;
   assign char_data_o  = mem[rd_ptr];

   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + CW'(1);
      end else if (pop && !push) begin
         count_next = count - CW'(1);
      end
   end

   // DRAIN leaves as soon as the FIFO will be empty after this edge, so done_o
   // follows the last pop by one cycle; a run that ends with an empty FIFO
   // still spends one cycle in DRAIN.
   always_comb begin
      state_next = state;
      case (state)
         ST_RUN:   if (fini_evt) state_next = ST_DRAIN;
         ST_DRAIN: if (count_next == '0) state_next = ST_DONE;
         ST_DONE:  state_next = ST_DONE;
         default:  state_next = ST_RUN;
      endcase
   end

   // Storage needs no reset: the count alone defines which entries are live.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= wdata_i[7:0];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= ST_RUN;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         fini_o     <= 1'b0;
         timeout_o  <= 1'b0;
         done_o     <= 1'b0;
         overflow_o <= 1'b0;
         mcycle_o   <= '0;
         minstret_o <= '0;
         br_pred_o  <= '0;
         br_misp_o  <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
         // Power-of-two depth: pointers wrap naturally.
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (fini_evt)    fini_o     <= 1'b1;
         if (timeout_evt) timeout_o  <= 1'b1;
         if (drop)        overflow_o <= 1'b1;
         if (state == ST_DONE) done_o <= 1'b1;
         if (cnt_en) begin
            mcycle_o <= mcycle_o + 64'd1;
            if (retire_i) begin
               minstret_o <= minstret_o + 64'd1;
               if (ctrl_tsfr_i) begin
                  br_pred_o <= br_pred_o + 64'd1;
                  if (br_misp_i) br_misp_o <= br_misp_o + 64'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sim_host_console.sv
`timescale 1ns/1ps
// Bench for sim_host_console: table-driven store and retire vectors, a byte
// scoreboard checked on every drain handshake, and hand-written sequences for
// overflow, end-of-run, timeout and reset-during-drain.
module tb_sim_host_console;

   localparam int          DEPTH = 16;
   localparam logic [31:0] FINI  = 32'h00020000;
   localparam int          TMO   = 100;

   logic        clk;
   logic        rst;
   logic        wvalid;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        retire;
   logic        ctrl_tsfr;
   logic        br_misp;
   logic        busy;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        char_ready;
   logic        fini;
   logic        timeout;
   logic        done;
   logic        overflow;
   logic [63:0] mcycle;
   logic [63:0] minstret;
   logic [63:0] br_pred;
   logic [63:0] br_misp_cnt;

   sim_host_console #(
      .FIFO_DEPTH    (DEPTH),
      .FINI_CODE     (FINI),
      .TIMEOUT_CYCLES(64'(TMO))
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .wvalid_i    (wvalid),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .retire_i    (retire),
      .ctrl_tsfr_i (ctrl_tsfr),
      .br_misp_i   (br_misp),
      .busy_o      (busy),
      .char_valid_o(char_valid),
      .char_data_o (char_data),
      .char_ready_i(char_ready),
      .fini_o      (fini),
      .timeout_o   (timeout),
      .done_o      (done),
      .overflow_o  (overflow),
      .mcycle_o    (mcycle),
      .minstret_o  (minstret),
      .br_pred_o   (br_pred),
      .br_misp_o   (br_misp_cnt)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Compares any byte handed over at the coming edge, then advances to 1 ns
   // after that edge, where outputs are sampled and the next inputs driven.
   task automatic cycle();
      logic [7:0] e;
      if (char_valid && char_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop actual=%0h required=none", char_data);
         end else begin
            e = exp_q.pop_front();
            check("pop_byte", {56'd0, char_data}, {56'd0, e});
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- drivers ----------------
   task automatic idle_inputs();
      wvalid    = 1'b0;
      addr      = 32'h0;
      wdata     = 32'h0;
      retire    = 1'b0;
      ctrl_tsfr = 1'b0;
      br_misp   = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      char_ready = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic store(input logic [31:0] d);
      wvalid = 1'b1;
      addr   = 32'h8000_0000;
      wdata  = d;
      cycle();
      wvalid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},     64'(busy), 64'd0);
      check({tag, "_valid"},    64'(char_valid), 64'd0);
      check({tag, "_fini"},     64'(fini), 64'd0);
      check({tag, "_timeout"},  64'(timeout), 64'd0);
      check({tag, "_done"},     64'(done), 64'd0);
      check({tag, "_overflow"}, 64'(overflow), 64'd0);
      check({tag, "_mcycle"},   mcycle, 64'd0);
      check({tag, "_minstret"}, minstret, 64'd0);
      check({tag, "_br_pred"},  br_pred, 64'd0);
      check({tag, "_br_misp"},  br_misp_cnt, 64'd0);
   endtask

   // ---------------- vector tables ----------------
   typedef struct {
      logic        wv;
      logic [31:0] a;
      logic [31:0] d;
      logic        exp_valid;
      logic [7:0]  exp_byte;
   } st_vec_t;

   typedef struct {
      logic ret;
      logic ctl;
      logic mis;
   } rt_vec_t;

   st_vec_t v1[7];
   rt_vec_t r5[12];

   initial begin
      logic [63:0] e_inst;
      logic [63:0] e_pred;
      logic [63:0] e_misp;
      int          n;

      // Store patterns with the drain always ready: one store per cycle, so a
      // byte is visible exactly in the cycle after its store.
      v1[0] = '{1'b1, 32'h8000_0000, 32'h0000_0048, 1'b1, 8'h48};
      v1[1] = '{1'b1, 32'h8000_0000, 32'h0000_0069, 1'b1, 8'h69};
      v1[2] = '{1'b0, 32'h8000_0000, 32'h0000_0055, 1'b0, 8'h00};
      v1[3] = '{1'b1, 32'h7fff_ffff, 32'h0000_0033, 1'b0, 8'h00};
      v1[4] = '{1'b1, 32'hffff_fffc, 32'h1234_56a5, 1'b1, 8'ha5};
      v1[5] = '{1'b1, 32'h8000_0010, 32'h0002_0001, 1'b1, 8'h01};
      v1[6] = '{1'b1, 32'h8000_0004, 32'h0000_01ff, 1'b1, 8'hff};

      // 10 retires, 4 of them control transfers, 1 mispredicted.
      r5[0]  = '{1'b1, 1'b0, 1'b0};
      r5[1]  = '{1'b1, 1'b1, 1'b0};
      r5[2]  = '{1'b0, 1'b1, 1'b1};
      r5[3]  = '{1'b1, 1'b0, 1'b1};
      r5[4]  = '{1'b1, 1'b1, 1'b1};
      r5[5]  = '{1'b1, 1'b0, 1'b0};
      r5[6]  = '{1'b0, 1'b0, 1'b0};
      r5[7]  = '{1'b1, 1'b1, 1'b0};
      r5[8]  = '{1'b1, 1'b0, 1'b0};
      r5[9]  = '{1'b1, 1'b0, 1'b0};
      r5[10] = '{1'b1, 1'b1, 1'b0};
      r5[11] = '{1'b1, 1'b0, 1'b0};

      rst = 1'b1;
      char_ready = 1'b0;
      idle_inputs();

      // ---- 1: basic character path ----
      do_reset();
      check_all_zero("reset");
      char_ready = 1'b1;
      foreach (v1[i]) begin
         wvalid = v1[i].wv;
         addr   = v1[i].a;
         wdata  = v1[i].d;
         if (v1[i].exp_valid) exp_q.push_back(v1[i].exp_byte);
         cycle();
         check($sformatf("t1_valid_%0d", i), 64'(char_valid), 64'(v1[i].exp_valid));
         if (v1[i].exp_valid) check($sformatf("t1_byte_%0d", i), 64'(char_data), 64'(v1[i].exp_byte));
      end
      idle_inputs();
      cycle();
      cycle();
      check("t1_drained", 64'(exp_q.size()), 64'd0);
      check("t1_overflow", 64'(overflow), 64'd0);
      check("t1_valid_idle", 64'(char_valid), 64'd0);

      // ---- 2: fill, overflow, drop on full even with a pop ----
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         exp_q.push_back(8'(8'h10 + i));
         store(32'h10 + 32'(i));
         check($sformatf("t2_busy_%0d", i), 64'(busy), 64'(i == DEPTH - 1));
      end
      check("t2_overflow_before", 64'(overflow), 64'd0);
      store(32'h99);
      check("t2_overflow", 64'(overflow), 64'd1);
      check("t2_busy_hold", 64'(busy), 64'd1);
      char_ready = 1'b1;
      store(32'haa);
      check("t2_busy_after_pop", 64'(busy), 64'd0);
      n = 0;
      while (exp_q.size() > 0 && n < 40) begin
         cycle();
         n++;
      end
      check("t2_drain_all", 64'(exp_q.size()), 64'd0);
      cycle();
      cycle();
      check("t2_empty", 64'(char_valid), 64'd0);

      // ---- 3: end-of-run with a pending byte ----
      do_reset();
      exp_q.push_back(8'h41);
      store(32'h41);
      store(FINI);
      check("t3_fini", 64'(fini), 64'd1);
      check("t3_timeout", 64'(timeout), 64'd0);
      check("t3_head", 64'(char_data), 64'h41);
      for (int i = 0; i < 5; i++) begin
         cycle();
         check($sformatf("t3_done_stall_%0d", i), 64'(done), 64'd0);
      end
      char_ready = 1'b1;
      cycle();
      char_ready = 1'b0;
      check("t3_done_at_pop", 64'(done), 64'd0);
      cycle();
      check("t3_done", 64'(done), 64'd1);
      char_ready = 1'b1;
      store(32'h77);
      check("t3_ignored_in_done", 64'(char_valid), 64'd0);
      check("t3_mcycle", mcycle, 64'd1);

      // ---- 4: timeout with no stores ----
      do_reset();
      n = 0;
      while (!fini && n < 200) begin
         cycle();
         n++;
      end
      check("t4_fini_cycle", 64'(n), 64'd102);
      check("t4_timeout", 64'(timeout), 64'd1);
      check("t4_mcycle", mcycle, 64'd101);
      check("t4_done_0", 64'(done), 64'd0);
      cycle();
      check("t4_done_1", 64'(done), 64'd0);
      cycle();
      check("t4_done_2", 64'(done), 64'd1);
      check("t4_mcycle_frozen", mcycle, 64'd101);

      // ---- 4b: timeout and end code in the same cycle ----
      do_reset();
      for (int i = 0; i < TMO + 1; i++) cycle();
      check("t4b_no_fini_yet", 64'(fini), 64'd0);
      store(FINI);
      check("t4b_fini", 64'(fini), 64'd1);
      check("t4b_timeout", 64'(timeout), 64'd1);
      check("t4b_mcycle", mcycle, 64'd101);

      // ---- 5: retire counters ----
      do_reset();
      e_inst = '0;
      e_pred = '0;
      e_misp = '0;
      foreach (r5[i]) begin
         retire    = r5[i].ret;
         ctrl_tsfr = r5[i].ctl;
         br_misp   = r5[i].mis;
         cycle();
         if (r5[i].ret) e_inst++;
         if (r5[i].ret && r5[i].ctl) e_pred++;
         if (r5[i].ret && r5[i].ctl && r5[i].mis) e_misp++;
         check($sformatf("t5_minstret_%0d", i), minstret, e_inst);
      end
      retire    = 1'b1;
      ctrl_tsfr = 1'b1;
      br_misp   = 1'b1;
      store(FINI);
      cycle();
      cycle();
      idle_inputs();
      check("t5_minstret", minstret, 64'd10);
      check("t5_br_pred", br_pred, 64'd4);
      check("t5_br_misp", br_misp_cnt, 64'd1);
      check("t5_model_pred", br_pred, e_pred);
      check("t5_model_misp", br_misp_cnt, e_misp);
      check("t5_mcycle", mcycle, 64'd12);

      // ---- 6: reset while draining ----
      do_reset();
      for (int i = 0; i < 3; i++) store(32'h30 + 32'(i));
      store(FINI);
      check("t6_fini", 64'(fini), 64'd1);
      check("t6_pending", 64'(char_valid), 64'd1);
      rst = 1'b1;
      #1;
      check_all_zero("t6_async");
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      char_ready = 1'b1;
      exp_q.push_back(8'h5a);
      store(32'h5a);
      check("t6_new_valid", 64'(char_valid), 64'd1);
      check("t6_new_byte", 64'(char_data), 64'h5a);
      cycle();
      check("t6_fini_clear", 64'(fini), 64'd0);
      check("t6_empty", 64'(char_valid), 64'd0);
      check("t6_sb_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
